// File: rtl/fifo_uart_tx.sv
// Pops bytes from a 4-entry FIFO (one-cycle read latency) and serialises each
// one onto a UART 8N1 line, LSB first.
//
// state   | meaning
// IDLE    | line high, pop when FIFO not empty
// CAPTURE | line high, FIFO data valid this cycle
// START   | start bit (low) for CLKS_PER_BIT cycles
// DATA    | eight data bits, CLKS_PER_BIT cycles each
// STOP    | stop bit (high) for CLKS_PER_BIT cycles
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          cyc_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign cyc_last = (cyc_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        shift_d    = shift_q;
        fifo_rd_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // Pop is held off while reset is asserted even though state reads IDLE.
                if (!fifo_empty && rstn) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_CAPTURE;
                    busy_d     = 1'b1;
                end
            end
            S_CAPTURE: begin
                shift_d   = fifo_data;
                tx_d      = 1'b0;
                cyc_cnt_d = '0;
                state_d   = S_START;
            end
            S_START: begin
                if (cyc_last) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cyc_last) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cyc_last) begin
                    cyc_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
